// File: rtl/mul6_share_ctrl.sv
// Two-port round-robin front end for one shared 6x6 signed multiplier.
// Operands are registered so the multiplier's carry chain stays internal.
module s6bitmultiplier (
  output logic [11:0] product,
  input  logic [5:0]  a,
  input  logic [5:0]  b
);
  logic [11:0] ea;
  logic [11:0] pp;
  logic [11:0] acc;

  assign ea = {{6{a[5]}}, a};

  // Row 5 carries the sign weight of b, so it is subtracted.
  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < 6; i++) begin
      pp = (ea & {12{b[i]}}) << i;
      if (i == 5) acc = acc - pp;
      else        acc = acc + pp;
    end
  end

  assign product = acc;
endmodule

module mul6_share_ctrl #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_a,
  input  logic [5:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_a,
  input  logic [5:0]  req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [11:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  a_q;
  logic [5:0]  b_q;
  logic        id_q;
  logic        last_q;
  logic [3:0]  cnt_q;
  logic [11:0] mul_p;
  logic        grant;
  logic        hs;

  s6bitmultiplier u_mul (
    .product (mul_p),
    .a       (a_q),
    .b       (b_q)
  );

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) & ~grant & req0_valid;
  assign req1_ready = (state_q == IDLE) &  grant & req1_valid;
  assign hs         = req0_ready | req1_ready;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      product    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            a_q     <= grant ? req1_a : req0_a;
            b_q     <= grant ? req1_b : req0_b;
            id_q    <= grant;
            last_q  <= grant;
            cnt_q   <= CNT_INIT;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == 4'd0) begin
            product    <= mul_p;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul6_share_ctrl.sv
// Bench for mul6_share_ctrl: two instances (settle 1 and 4) on shared inputs,
// checked against an integer-arithmetic product model and a grant queue.
module tb_mul6_share_ctrl;
  logic        clk;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [5:0]  a0, b0, a1, b1;
  logic        rd0_1, rd1_1, rv_1, rid_1, busy_1;
  logic [11:0] p_1;
  logic        rd0_4, rd1_4, rv_4, rid_4, busy_4;
  logic [11:0] p_4;
  int          checks;
  int          failures;

  mul6_share_ctrl #(.CALC_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rd0_1), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rd1_1), .req1_a(a1), .req1_b(b1),
    .resp_valid(rv_1), .resp_ready(rr), .resp_id(rid_1),
    .product(p_1), .busy(busy_1)
  );

  mul6_share_ctrl #(.CALC_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rd0_4), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rd1_4), .req1_a(a1), .req1_b(b1),
    .resp_valid(rv_4), .resp_ready(rr), .resp_id(rid_4),
    .product(p_4), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    int sa, sb, p;
    sa = a[5] ? int'(a) - 64 : int'(a);
    sb = b[5] ? int'(b) - 64 : int'(b);
    p  = sa * sb;
    return p[11:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rv1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv_1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (rv_1 !== 1'b0 || busy_1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u1_flags got rv=%b busy=%b exp 0 0", rv_1, busy_1);
    end
    checks++;
    if (p_1 !== 12'h000 || rid_1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u1_data got p=%h id=%b exp 000 0", p_1, rid_1);
    end
    checks++;
    if (rv_4 !== 1'b0 || busy_4 !== 1'b0 || p_4 !== 12'h000 || rid_4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u4 got rv=%b busy=%b p=%h id=%b exp 0 0 000 0",
               rv_4, busy_4, p_4, rid_4);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1'b1; a0 = 6'h3D; b0 = 6'd5; rr = 1'b1;
    #1;
    checks++;
    if (rd0_1 !== 1'b1 || rd1_1 !== 1'b0) begin
      failures++;
      $display("FAIL single_ready got r0=%b r1=%b exp 1 0", rd0_1, rd1_1);
    end
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rd0_1 !== 1'b0 || busy_1 !== 1'b1 || rv_1 !== 1'b0) begin
      failures++;
      $display("FAIL single_calc got r0=%b busy=%b rv=%b exp 0 1 0", rd0_1, busy_1, rv_1);
    end
    @(negedge clk);
    checks++;
    if (rv_1 !== 1'b1 || busy_1 !== 1'b1) begin
      failures++;
      $display("FAIL single_resp got rv=%b busy=%b exp 1 1", rv_1, busy_1);
    end
    checks++;
    if (p_1 !== 12'hFF1 || rid_1 !== 1'b0) begin
      failures++;
      $display("FAIL single_product got p=%h id=%b exp ff1 0", p_1, rid_1);
    end
    @(negedge clk);
    checks++;
    if (rv_1 !== 1'b0 || busy_1 !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got rv=%b busy=%b exp 0 0", rv_1, busy_1);
    end
  endtask

  task automatic run_contention(input int n, input bit rnd,
                                input logic [5:0] fa0, input logic [5:0] fb0,
                                input logic [5:0] fa1, input logic [5:0] fb1);
    logic [11:0] exp_p[$];
    logic        exp_id[$];
    logic [11:0] ep;
    logic        eid;
    int          grants, resps, cyc;
    bit          h0, h1;
    do_reset();
    rr = 1'b1;
    a0 = rnd ? 6'($urandom) : fa0;
    b0 = rnd ? 6'($urandom) : fb0;
    a1 = rnd ? 6'($urandom) : fa1;
    b1 = rnd ? 6'($urandom) : fb1;
    grants = 0; resps = 0; cyc = 0;
    @(posedge clk);
    #1 v0 = 1'b1; v1 = 1'b1;
    while (resps < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      h0 = rd0_1;
      h1 = rd1_1;
      checks++;
      if (h0 && h1) begin
        failures++;
        $display("FAIL both_ready got r0=%b r1=%b exp not both", h0, h1);
      end
      if (h0 || h1) begin
        checks++;
        if (int'(h1) != grants % 2) begin
          failures++;
          $display("FAIL grant_order got %0d exp %0d at grant %0d",
                   int'(h1), grants % 2, grants);
        end
        exp_id.push_back(h1);
        exp_p.push_back(h1 ? ref_mul(a1, b1) : ref_mul(a0, b0));
        grants++;
      end
      if (rv_1) begin
        resps++;
        checks++;
        if (exp_p.size() == 0) begin
          failures++;
          $display("FAIL spurious_resp got id=%b p=%h exp none", rid_1, p_1);
        end else begin
          ep  = exp_p.pop_front();
          eid = exp_id.pop_front();
          if (rid_1 !== eid || p_1 !== ep) begin
            failures++;
            $display("FAIL contention_resp got id=%b p=%h exp id=%b p=%h",
                     rid_1, p_1, eid, ep);
          end
        end
      end
      @(posedge clk);
      #1;
      if (grants >= n) begin
        v0 = 1'b0; v1 = 1'b0;
      end else if (rnd) begin
        if (h0) begin a0 = 6'($urandom); b0 = 6'($urandom); end
        if (h1) begin a1 = 6'($urandom); b1 = 6'($urandom); end
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    checks++;
    if (resps != n) begin
      failures++;
      $display("FAIL contention_count got %0d exp %0d", resps, n);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] e0, e1;
    bit ok;
    do_reset();
    rr = 1'b0;
    @(posedge clk);
    #1 v0 = 1'b1; a0 = 6'($urandom); b0 = 6'($urandom);
    e0 = ref_mul(a0, b0);
    @(posedge clk);
    #1 v0 = 1'b0; v1 = 1'b1; a1 = 6'($urandom); b1 = 6'($urandom);
    e1 = ref_mul(a1, b1);
    wait_rv1(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_first_resp got timeout exp resp_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rv_1 !== 1'b1 || p_1 !== e0 || rid_1 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold got rv=%b p=%h id=%b exp 1 %h 0", rv_1, p_1, rid_1, e0);
      end
      checks++;
      if (rd0_1 !== 1'b0 || rd1_1 !== 1'b0 || busy_1 !== 1'b1) begin
        failures++;
        $display("FAIL bp_ready got r0=%b r1=%b busy=%b exp 0 0 1", rd0_1, rd1_1, busy_1);
      end
    end
    rr = 1'b1;
    #1;
    checks++;
    if (rd1_1 !== 1'b0) begin
      failures++;
      $display("FAIL bp_consume_ready got %b exp 0", rd1_1);
    end
    @(negedge clk);
    checks++;
    if (rv_1 !== 1'b0 || busy_1 !== 1'b0 || rd1_1 !== 1'b1) begin
      failures++;
      $display("FAIL bp_next got rv=%b busy=%b r1=%b exp 0 0 1", rv_1, busy_1, rd1_1);
    end
    @(posedge clk);
    #1 v1 = 1'b0;
    a1 = ~a1;
    wait_rv1(ok);
    checks++;
    if (!ok || rid_1 !== 1'b1 || p_1 !== e1) begin
      failures++;
      $display("FAIL bp_second got ok=%b id=%b p=%h exp 1 1 %h", ok, rid_1, p_1, e1);
    end
  endtask

  task automatic test_settle4();
    logic [11:0] e;
    do_reset();
    rr = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b1; a0 = 6'($urandom); b0 = 6'($urandom);
    e = ref_mul(a0, b0);
    @(negedge clk);
    checks++;
    if (rd0_4 !== 1'b1) begin
      failures++;
      $display("FAIL s4_ready got %b exp 1", rd0_4);
    end
    @(posedge clk);
    #1 v0 = 1'b0; a0 = a0 + 6'd7; b0 = ~b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rv_4 !== (k == 4)) begin
        failures++;
        $display("FAIL s4_latency got rv=%b exp %b after edge %0d", rv_4, (k == 4), k);
      end
    end
    checks++;
    if (p_4 !== e || rid_4 !== 1'b0) begin
      failures++;
      $display("FAIL s4_product got p=%h id=%b exp %h 0", p_4, rid_4, e);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    rr = 1'b0;
    @(posedge clk);
    #1 v0 = 1'b1; a0 = 6'($urandom); b0 = 6'($urandom);
    @(posedge clk);
    #1 v0 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rv_1 !== 1'b1 || busy_4 !== 1'b1) begin
      failures++;
      $display("FAIL midop_pre got rv1=%b busy4=%b exp 1 1", rv_1, busy_4);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rv_1 !== 1'b0 || busy_1 !== 1'b0 || rv_4 !== 1'b0 || busy_4 !== 1'b0) begin
      failures++;
      $display("FAIL midop_async got rv1=%b b1=%b rv4=%b b4=%b exp 0 0 0 0",
               rv_1, busy_1, rv_4, busy_4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rv_1 !== 1'b0 || rv_4 !== 1'b0 || busy_1 !== 1'b0 || busy_4 !== 1'b0) begin
        failures++;
        $display("FAIL midop_after got rv1=%b rv4=%b b1=%b b4=%b exp 0 0 0 0",
                 rv_1, rv_4, busy_1, busy_4);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] e;
    bit ok;
    bit abort;
    do_reset();
    rr = 1'b1;
    abort = 1'b0;
    for (int ai = 0; ai < 64 && !abort; ai++) begin
      for (int bi = 0; bi < 64 && !abort; bi++) begin
        @(posedge clk);
        #1 v0 = 1'b1; a0 = 6'(ai); b0 = 6'(bi);
        e = ref_mul(a0, b0);
        @(posedge clk);
        #1 v0 = 1'b0;
        wait_rv1(ok);
        checks++;
        if (!ok || p_1 !== e) begin
          failures++;
          $display("FAIL sweep a=%h b=%h got ok=%b p=%h exp %h", a0, b0, ok, p_1, e);
          if (!ok) abort = 1'b1;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    run_contention(2, 1'b0, 6'h20, 6'h20, 6'h1F, 6'h20);
    run_contention(8, 1'b1, '0, '0, '0, '0);
    test_backpressure();
    test_settle4();
    test_reset_midop();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul6_share_ctrl.md
Name: mul6_share_ctrl

Overview:
- Sequences and shares one instance of the team's 6-bit signed array multiplier (s6bitmultiplier: product, a, b) between two requesters.
- Round-robin arbitration, valid/ready handshake on both request ports, registered operands, configurable settle time, and a single registered response port tagged with the requester id.
- Sits between the two datapath clients and the combinational multiplier, so the multiplier's long carry chain never lies on a requester's timing path.

Parameters:
- CALC_CYCLES, 1, clock cycles the multiplier inputs are held stable before the product is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  6  requester 0 multiplicand, two's complement.
- req0_b  input  6  requester 0 multiplier, two's complement.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- resp_valid  output  1  product and resp_id are valid.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  1  requester that issued the operation.
- product  output  12  signed product, two's complement.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync-safe release) forces:
  - state=IDLE, resp_valid=0, product=0, resp_id=0, busy=0;
  - operand registers=0, settle counter=0, last_grant=1 (so requester 0 wins the first contention).
- States: IDLE, CALC, RESP.
- IDLE:
  - grant = sole valid requester; if both are valid, grant goes to the requester not equal to last_grant.
  - reqX_ready = (state==IDLE) & (grant==X) & reqX_valid. Combinational from valid is permitted; at most one ready is high per cycle.
  - On handshake: latch a, b and id; last_grant<=id; counter<=CALC_CYCLES-1; state->CALC.
- CALC:
  - Multiplier inputs driven only from the operand registers.
  - If counter==0: product<=multiplier output, resp_id<=latched id, resp_valid<=1, state->RESP. Otherwise counter decrements.
- RESP:
  - product, resp_id and resp_valid are held stable until resp_ready=1.
  - On that edge: resp_valid<=0, state->IDLE. product keeps its last value.
- Latency and throughput:
  - Handshake at edge T gives resp_valid high after edge T+CALC_CYCLES.
  - Peak throughput is one op per CALC_CYCLES+2 cycles with resp_ready tied high.
  - No new request is accepted in CALC or RESP (both readies low), including the cycle in which the response is consumed.
- Arithmetic: full 12-bit signed result, no saturation. The range -32*-32=+1024 through 31*-32=-992 must be exact.
- Protocol:
  - Requesters hold valid and operands until ready. The DUT samples operands only at the handshake, so later operand changes have no effect.
  - A requester deasserting valid before the grant simply forfeits that cycle; no state change.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- Reset mid-operation: the in-flight op is discarded, resp_valid drops immediately (async), and no response is issued after release.

Test Plan:
- Reset then req0 only, a=-3 (6'h3D), b=5, CALC_CYCLES=1, resp_ready=1 -> req0_ready pulses one cycle; one cycle later resp_valid=1, product=12'hFF1, resp_id=0; busy high for 2 cycles.
- Both valid, req0 a=-32,b=-32 and req1 a=31,b=-32, resp_ready=1 -> req0 served first (product=12'h400, id 0), then req1 (product=12'hC20, id 1); ready never high on both ports.
- Continuous contention over 8 operations -> grant sequence 0,1,0,1,0,1,0,1; every response id matches its grant order.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> product/resp_id stable, both readies low, busy high; resp_ready=1 -> IDLE, next request accepted the following cycle.
- CALC_CYCLES=4, operands changed on the cycle after the handshake -> resp_valid exactly 4 cycles after the handshake with the product of the originally captured operands.
- rst_n asserted during CALC -> resp_valid=0, busy=0 at once; after release with no requests, resp_valid stays 0.
- Exhaustive 4096-pair sweep on requester 0 -> product equals the signed reference model for every pair.
